// File: rtl/watch_time_counter_if.sv
// watch_time_counter_if: button pulses in, BCD time digits and status pulses out.
interface watch_time_counter_if;
  logic       mode_p;
  logic       inc_p;
  logic [3:0] hr_t;
  logic [3:0] hr_o;
  logic [3:0] min_t;
  logic [3:0] min_o;
  logic [3:0] sec_t;
  logic [3:0] sec_o;
  logic [1:0] set_mode;
  logic       tick;
  logic       midnight;
  modport master(output mode_p, inc_p,
                 input hr_t, hr_o, min_t, min_o, sec_t, sec_o, set_mode, tick, midnight);
  modport slave(input mode_p, inc_p,
                output hr_t, hr_o, min_t, min_o, sec_t, sec_o, set_mode, tick, midnight);
endinterface

// File: rtl/watch_time_counter.sv
// watch_time_counter: 1 Hz prescaler and 24-hour BCD hh:mm:ss clock with hour/minute set modes.
module watch_time_counter #(
  parameter logic [31:0] CLK_DIV = 32'd50_000_000
) (
  input logic clk,
  input logic rst,
  watch_time_counter_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} mode_t;
  mode_t mode, mode_nx;
  logic [31:0] presc;
  logic [3:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o;
  logic tick, midnight;
  logic adv, inc_ok, sec_wrap, min_wrap, hr_wrap, min_inc, hr_inc;
  always_comb begin
    mode_nx = !bus.mode_p ? mode : mode == RUN ? SET_HR : mode == SET_HR ? SET_MIN : RUN;
    adv = mode == RUN && presc == CLK_DIV - 32'd1;
    inc_ok = bus.inc_p && !bus.mode_p;
    sec_wrap = sec_t == 4'd5 && sec_o == 4'd9;
    min_wrap = min_t == 4'd5 && min_o == 4'd9;
    hr_wrap = hr_t == 4'd2 && hr_o == 4'd3;
    // Set-mode minute increments never carry into hours
    min_inc = (adv && sec_wrap) || (mode == SET_MIN && inc_ok);
    hr_inc = (adv && sec_wrap && min_wrap) || (mode == SET_HR && inc_ok);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) mode <= RUN;
    else mode <= mode_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc <= 32'd0;
      {hr_t, hr_o, min_t, min_o, sec_t, sec_o} <= 24'd0;
      tick <= 1'b0;
      midnight <= 1'b0;
    end else begin
      // Held at zero outside RUN so a return to RUN restarts a full second
      presc <= (mode == RUN && !bus.mode_p && !adv) ? presc + 32'd1 : 32'd0;
      tick <= adv;
      midnight <= adv && sec_wrap && min_wrap && hr_wrap;
      if (adv) begin
        sec_o <= sec_o == 4'd9 ? 4'd0 : sec_o + 4'd1;
        if (sec_o == 4'd9) sec_t <= sec_t == 4'd5 ? 4'd0 : sec_t + 4'd1;
      end else if (mode == SET_MIN && inc_ok) begin
        sec_o <= 4'd0;
        sec_t <= 4'd0;
      end
      if (min_inc) begin
        min_o <= min_o == 4'd9 ? 4'd0 : min_o + 4'd1;
        if (min_o == 4'd9) min_t <= min_t == 4'd5 ? 4'd0 : min_t + 4'd1;
      end
      if (hr_inc) begin
        hr_o <= (hr_wrap || hr_o == 4'd9) ? 4'd0 : hr_o + 4'd1;
        hr_t <= hr_wrap ? 4'd0 : hr_o == 4'd9 ? hr_t + 4'd1 : hr_t;
      end
    end
  assign bus.hr_t = hr_t;
  assign bus.hr_o = hr_o;
  assign bus.min_t = min_t;
  assign bus.min_o = min_o;
  assign bus.sec_t = sec_t;
  assign bus.sec_o = sec_o;
  assign bus.set_mode = mode;
  assign bus.tick = tick;
  assign bus.midnight = midnight;
endmodule

// File: doc/watch_time_counter.md
# watch_time_counter

Timekeeping core of the digital watch: divides the system clock to a 1 Hz tick and maintains a 24-hour hh:mm:ss time as six BCD digits. Each digit output drives one instance of the BCD-to-seven-segment decoder stage directly downstream. Two debounced single-cycle button pulses select a set mode and increment hours or minutes.

## Interface
- CLK_DIV, default 50_000_000: system-clock cycles per second; legal range 2 to 2^32-1. Benches use 4.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode_p  in  1  single-cycle pulse, already debounced; advances the set mode.
- inc_p  in  1  single-cycle pulse, already debounced; increments the field being set.
- hr_t  out  4  hours tens digit, BCD 0–2.
- hr_o  out  4  hours ones digit, BCD 0–9.
- min_t  out  4  minutes tens digit, BCD 0–5.
- min_o  out  4  minutes ones digit, BCD 0–9.
- sec_t  out  4  seconds tens digit, BCD 0–5.
- sec_o  out  4  seconds ones digit, BCD 0–9.
- set_mode  out  2  current mode: 0 = RUN, 1 = SET_HR, 2 = SET_MIN; 3 never appears.
- tick  out  1  one-cycle pulse on each seconds advance.
- midnight  out  1  one-cycle pulse on the 23:59:59 to 00:00:00 rollover.

## Operation
- Reset state:
  - All digits 0 (time 00:00:00).
  - set_mode = RUN.
  - Prescaler = 0.
  - tick = 0, midnight = 0.
- Prescaler:
  - 32-bit counter, counts 0 to CLK_DIV-1, and only in RUN.
  - On the edge where the prescaler equals CLK_DIV-1 in RUN: prescaler goes to 0, seconds advance, tick is registered high for one cycle.
- Seconds advance (BCD, all digit updates on the same edge):
  - sec_o 9 → 0 with carry into sec_t.
  - sec_t 5 → 0 with carry into minutes.
  - min_o and min_t carry the same way; the minutes carry feeds hours.
  - Hours: 23 → 00. Otherwise hr_o 9 → 0 with carry into hr_t.
- On 23:59:59 → 00:00:00, midnight is registered high together with tick.
- Mode FSM, advanced by mode_p:
  - RUN → SET_HR → SET_MIN → RUN.
  - Entering SET_HR: prescaler is cleared and held at 0 while not in RUN; the time is frozen.
  - Leaving SET_MIN for RUN: the prescaler starts from 0, so the first tick comes CLK_DIV cycles after the transition edge.
- inc_p behaviour by mode:
  - RUN: ignored.
  - SET_HR: hours +1, wrapping 23 → 00. Minutes and seconds unchanged. No tick, no midnight.
  - SET_MIN: minutes +1, wrapping 59 → 00 with no carry into hours. Seconds cleared to 00. No tick.
- Simultaneous events:
  - mode_p and inc_p in the same cycle: mode_p takes effect and inc_p is discarded.
  - mode_p on a prescaler-terminal cycle in RUN: the seconds advance and tick both happen, and set_mode goes to SET_HR on the same edge.
- All outputs are registered. No combinational path runs from any input to any output.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously. Operation resumes on the first rising edge after rst deasserts, with the prescaler counting from 0.

## Timing
- First tick after reset release: the prescaler equals CLK_DIV-1 on the CLK_DIV-th rising edge after rst deasserts, so tick is high during the cycle after that edge.
- In steady RUN, tick has a period of exactly CLK_DIV cycles, with no drift across carries or across midnight.
- Latency, pulse to updated output:
  - mode_p to set_mode: 1 cycle.
  - inc_p to digits: 1 cycle.
- Back-to-back inc_p on consecutive cycles: each pulse increments once.
- tick and midnight are never high for more than one consecutive cycle.

## Test plan
- Reset and count, CLK_DIV=4: release rst, then run 4×61 cycles. Required: first tick on the 4th edge; time reads 00:01:01; exactly 61 tick pulses.
- Midnight rollover: set 23:59 via the set modes, return to RUN, wait 60 ticks. Required: time reads 00:00:00, midnight is high on exactly one cycle coincident with the 60th tick, and time reads 00:00:01 one tick later.
- Set wraps:
  - In SET_HR, 25 inc_p from 00: hours read 01.
  - In SET_MIN, 61 inc_p from 00: minutes read 01, hours unchanged, seconds 00.
  - No tick is seen while in either set mode.
- Simultaneous events:
  - mode_p and inc_p together in SET_HR: set_mode becomes SET_MIN and hours are unchanged.
  - mode_p on a terminal prescaler cycle in RUN: seconds advance by 1, tick is seen, and set_mode = SET_HR.
- Async reset mid-count: at time 12:34:56, assert rst between clock edges. Required: all digits, set_mode, tick and midnight go to 0 before the next edge. After release, the first tick comes CLK_DIV edges later.
- Resume timing: mode_p three times from RUN back to RUN. Required: no tick for CLK_DIV-1 cycles after the return edge, and the tick arrives on the CLK_DIV-th edge.
